// File: rtl/seq_multiply.sv
// seq_multiply -- sequential shift-add multiplier for sign-magnitude operands.
//
// One shift-add step is performed per clock in CALC. The product sign is the
// XOR of the operand signs, forced to 0 when the magnitude is zero.
//
// Optional feature: define SEQ_MULTIPLY_EARLY_EXIT_EN to end CALC as soon as
// the remaining multiplier bits are all zero (at least one step always runs).
//
// Ports:
//   clk    sole clock, rising edge
//   rst    synchronous active-high reset
//   start  begin a multiply (sampled only in IDLE)
//   X, Y   operands, sign-magnitude, [N] sign, [N-1:0] magnitude
//   busy   high while in CALC
//   done   one-cycle pulse: Res holds a new product
//   Res    product, sign-magnitude, [2N] sign, [2N-1:0] magnitude
//
// state | meaning
// IDLE  | waiting for start, operands loaded on acceptance
// CALC  | one shift-add step per cycle
// DONE  | Res updated, done asserted for this single cycle
module seq_multiply #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N:0]   X,
    input  logic [N:0]   Y,
    output logic         busy,
    output logic         done,
    output logic [2*N:0] Res
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [2*N-1:0]   mcand;
    logic [2*N-1:0]   acc;
    logic [2*N-1:0]   acc_nx;
    logic [N-1:0]     mplier;
    logic             sign;
    logic [CW-1:0]    cnt;
    logic             last_step;

    assign acc_nx = mplier[0] ? (acc + mcand) : acc;

`ifdef SEQ_MULTIPLY_EARLY_EXIT_EN
    // Stop once the multiplier left after this step's shift has no set bits.
    assign last_step = (cnt == CW'(N - 1)) || (mplier[N-1:1] == '0);
`else
    assign last_step = (cnt == CW'(N - 1));
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (last_step) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            sign   <= 1'b0;
            cnt    <= '0;
            Res    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{N{1'b0}}, X[N-1:0]};
                        mplier <= Y[N-1:0];
                        sign   <= X[N] ^ Y[N];
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_step) begin
                        // no negative zero
                        Res <= {sign & (|acc_nx), acc_nx};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiply.sv
// tb_seq_multiply -- directed self-checking bench for seq_multiply (N=8).
// Latency expectations follow SEQ_MULTIPLY_EARLY_EXIT_EN when it is defined.
module tb_seq_multiply;

    logic        clk;
    logic        rst;
    logic        start;
    logic [8:0]  X;
    logic [8:0]  Y;
    logic        busy;
    logic        done;
    logic [16:0] Res;

    int errors = 0;
    int checks = 0;

    seq_multiply #(.N(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .X     (X),
        .Y     (Y),
        .busy  (busy),
        .done  (done),
        .Res   (Res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected edges from acceptance to done.
    function automatic int lat_for(input logic [8:0] y);
        int p;
        p = 0;
`ifdef SEQ_MULTIPLY_EARLY_EXIT_EN
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = i + 1;
        end
        if (p < 1) p = 1;
`else
        p = 8;
`endif
        return p;
    endfunction

    task automatic run(input string tag, input logic [8:0] x, input logic [8:0] y,
                       input logic [16:0] exp_res);
        int lat;
        int nbusy;
        @(negedge clk);
        X = x;
        Y = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        nbusy = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, lat_for(y));
        chk({tag, "_busy"}, nbusy, lat_for(y));
        chk({tag, "_res"}, Res, exp_res);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_res_hold"}, Res, exp_res);
    endtask

    initial begin
        int ndone;
        logic [16:0] res_seen;

        rst = 1'b1;
        start = 1'b0;
        X = '0;
        Y = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res", Res, 0);
        @(negedge clk);
        rst = 1'b0;

        // start=0 keeps IDLE
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);

        run("neg_5x3", 9'h005, 9'h103, 17'h1000F);
        run("max", 9'h1FF, 9'h1FF, 17'h0FE01);
        run("negzero", 9'h100, 9'h007, 17'h00000);
        run("ff_x1", 9'h0FF, 9'h001, 17'h000FF);
        run("ff_x0", 9'h0FF, 9'h000, 17'h00000);
        run("3x128", 9'h003, 9'h180, 17'h10180);

        // Reset four steps into CALC aborts with no done and clears Res.
        @(negedge clk);
        X = 9'h0AB;
        Y = 9'h0FF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_res", Res, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run("after_abort", 9'h002, 9'h003, 17'h00006);

        // start held through CALC with operands changing: one done only.
        @(negedge clk);
        X = 9'h00A;
        Y = 9'h10C;
        start = 1'b1;
        ndone = 0;
        res_seen = '0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 30; c++) begin
            X = 9'($urandom);
            Y = 9'($urandom);
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                res_seen = Res;
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("hold_ndone", ndone, 1);
        chk("hold_res", res_seen, 17'h10078);
        chk("hold_res_kept", Res, 17'h10078);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
